// File: rtl/axil_burst_master.sv
// -----------------------------------------------------------------------------
// axil_burst_master
//   AXI-Lite master that executes one command as cmd_len sequential single-beat
//   transfers. The address advances by DATA_W/8 per beat. Write data is popped
//   from a show-ahead TX FIFO; read data is pushed straight into an RX FIFO.
//   Each phase has a handshake timeout. A per-command status is reported with
//   the done pulse.
//
// Ports
//   clk, reset_n                      clock, async active-low reset
//   i_cmd_valid / o_cmd_ready         command handshake (ready only when idle)
//   i_cmd_write, i_cmd_addr, i_cmd_len  direction, start address, beat count
//   o_busy                            command in progress
//   o_done                            1-cycle pulse at command end
//   o_done_status                     00 OK, 01 SLVERR/DECERR, 10 timeout
//   o_done_beats                      beats completed with OKAY response
//   o_aw*/o_w*/i_b*, o_ar*/i_r*       AXI-Lite write and read channels
//   i_tx_fifo_data/empty, o_tx_fifo_rd_en   TX FIFO head and pop
//   o_rx_fifo_data, i_rx_fifo_full, o_rx_fifo_wr_en  RX FIFO push side
// -----------------------------------------------------------------------------
module axil_burst_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 16,
  parameter int TMO_W   = 8,
  parameter int TMO_MAX = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  // command
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic                i_cmd_write,
  input  logic [ADDR_W-1:0]   i_cmd_addr,
  input  logic [LEN_W-1:0]    i_cmd_len,
  output logic                o_busy,
  output logic                o_done,
  output logic [1:0]          o_done_status,
  output logic [LEN_W-1:0]    o_done_beats,
  // AXI-Lite write
  output logic [ADDR_W-1:0]   o_awaddr,
  output logic                o_awvalid,
  input  logic                i_awready,
  output logic [DATA_W-1:0]   o_wdata,
  output logic [DATA_W/8-1:0] o_wstrb,
  output logic                o_wvalid,
  input  logic                i_wready,
  input  logic [1:0]          i_bresp,
  input  logic                i_bvalid,
  output logic                o_bready,
  // AXI-Lite read
  output logic [ADDR_W-1:0]   o_araddr,
  output logic                o_arvalid,
  input  logic                i_arready,
  input  logic [DATA_W-1:0]   i_rdata,
  input  logic [1:0]          i_rresp,
  input  logic                i_rvalid,
  output logic                o_rready,
  // FIFOs
  input  logic [DATA_W-1:0]   i_tx_fifo_data,
  input  logic                i_tx_fifo_empty,
  output logic                o_tx_fifo_rd_en,
  output logic [DATA_W-1:0]   o_rx_fifo_data,
  input  logic                i_rx_fifo_full,
  output logic                o_rx_fifo_wr_en
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WR    = 3'd1;  // AW and W in flight
  localparam logic [2:0] S_WR_B  = 3'd2;
  localparam logic [2:0] S_RD_AR = 3'd3;
  localparam logic [2:0] S_RD_R  = 3'd4;
  localparam logic [2:0] S_NEXT  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_ERR = 2'b01;
  localparam logic [1:0] ST_TMO = 2'b10;

  localparam logic [ADDR_W-1:0] ADDR_INC  = ADDR_W'(DATA_W / 8);
  localparam logic [TMO_W-1:0]  TMO_LIMIT = TMO_W'(TMO_MAX);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic              r_write;
  logic [LEN_W-1:0]  r_beat_cnt;
  logic [LEN_W-1:0]  r_ok_cnt;
  logic [1:0]        r_status;
  logic [TMO_W-1:0]  r_tmo;
  logic              r_awvalid;
  logic              r_aw_done;
  logic              r_wvalid;
  logic              r_w_done;
  logic [DATA_W-1:0] r_wdata;
  logic              r_arvalid;
  logic              r_done;
  logic [1:0]        r_done_status;
  logic [LEN_W-1:0]  r_done_beats;

  logic             w_aw_fire;
  logic             w_w_fire;
  logic             w_ar_fire;
  logic             w_aw_all;
  logic             w_w_all;
  logic             w_tmo_hit;
  logic [LEN_W-1:0] w_beat_inc;

  assign w_aw_fire  = r_awvalid & i_awready;
  assign w_w_fire   = r_wvalid & i_wready;
  assign w_ar_fire  = r_arvalid & i_arready;
  // A handshake completing this cycle counts as done for the phase exit.
  assign w_aw_all   = r_aw_done | w_aw_fire;
  assign w_w_all    = r_w_done | w_w_fire;
  assign w_tmo_hit  = (r_tmo == TMO_LIMIT);
  assign w_beat_inc = r_beat_cnt + LEN_W'(1);

  assign o_cmd_ready     = (r_state == S_IDLE);
  assign o_busy          = (r_state != S_IDLE);
  assign o_done          = r_done;
  assign o_done_status   = r_done_status;
  assign o_done_beats    = r_done_beats;
  assign o_awaddr        = r_addr;
  assign o_awvalid       = r_awvalid;
  assign o_wdata         = r_wdata;
  assign o_wstrb         = '1;
  assign o_wvalid        = r_wvalid;
  assign o_bready        = (r_state == S_WR_B);
  assign o_araddr        = r_addr;
  assign o_arvalid       = r_arvalid;
  assign o_rready        = (r_state == S_RD_R);
  assign o_tx_fifo_rd_en = w_w_fire;
  assign o_rx_fifo_data  = i_rdata;
  // ARVALID was only raised with FIFO space, so every R beat can be pushed.
  assign o_rx_fifo_wr_en = (r_state == S_RD_R) & i_rvalid;

  // NOTE: every register here is updated with non-blocking assignments so all
  // reads in this block see pre-edge values; later assignments in the same
  // cycle override earlier defaults, which is how the aborts drop the valids.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_len         <= '0;
      r_write       <= 1'b0;
      r_beat_cnt    <= '0;
      r_ok_cnt      <= '0;
      r_status      <= ST_OK;
      r_tmo         <= '0;
      r_awvalid     <= 1'b0;
      r_aw_done     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_w_done      <= 1'b0;
      r_wdata       <= '0;
      r_arvalid     <= 1'b0;
      r_done        <= 1'b0;
      r_done_status <= ST_OK;
      r_done_beats  <= '0;
    end else begin
      r_done <= 1'b0;
      r_tmo  <= r_tmo + TMO_W'(1);

      case (r_state)
        S_IDLE: begin
          r_tmo <= '0;
          if (i_cmd_valid) begin
            r_addr     <= i_cmd_addr;
            r_len      <= i_cmd_len;
            r_write    <= i_cmd_write;
            r_beat_cnt <= '0;
            r_ok_cnt   <= '0;
            r_status   <= ST_OK;
            if (i_cmd_len == '0) begin
              r_state <= S_DONE;
            end else if (i_cmd_write) begin
              r_state   <= S_WR;
              r_awvalid <= 1'b1;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
              r_wvalid  <= ~i_tx_fifo_empty;
              r_wdata   <= i_tx_fifo_data;
            end else begin
              r_state   <= S_RD_AR;
              r_arvalid <= ~i_rx_fifo_full;
            end
          end
        end

        S_WR: begin
          if (w_aw_fire) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_fire) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end else if (!r_wvalid && !r_w_done && !i_tx_fifo_empty) begin
            // WDATA is captured with WVALID and then frozen until WREADY.
            r_wvalid <= 1'b1;
            r_wdata  <= i_tx_fifo_data;
          end
          if (w_aw_all && w_w_all) begin
            r_state <= S_WR_B;
            r_tmo   <= '0;
          end else if (w_aw_fire || w_w_fire) begin
            r_tmo <= '0;
          end else if (w_tmo_hit) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_status  <= ST_TMO;
            r_state   <= S_DONE;
            r_tmo     <= '0;
          end
        end

        S_WR_B: begin
          if (i_bvalid) begin
            r_tmo <= '0;
            if (i_bresp != 2'b00) begin
              r_status <= ST_ERR;
              r_state  <= S_DONE;
            end else begin
              r_state <= S_NEXT;
            end
          end else if (w_tmo_hit) begin
            r_status <= ST_TMO;
            r_state  <= S_DONE;
            r_tmo    <= '0;
          end
        end

        S_RD_AR: begin
          if (w_ar_fire) begin
            r_arvalid <= 1'b0;
            r_state   <= S_RD_R;
            r_tmo     <= '0;
          end else if (w_tmo_hit) begin
            r_arvalid <= 1'b0;
            r_status  <= ST_TMO;
            r_state   <= S_DONE;
            r_tmo     <= '0;
          end else if (!r_arvalid && !i_rx_fifo_full) begin
            r_arvalid <= 1'b1;
          end
        end

        S_RD_R: begin
          if (i_rvalid) begin
            r_tmo <= '0;
            if (i_rresp != 2'b00) begin
              r_status <= ST_ERR;
              r_state  <= S_DONE;
            end else begin
              r_state <= S_NEXT;
            end
          end else if (w_tmo_hit) begin
            r_status <= ST_TMO;
            r_state  <= S_DONE;
            r_tmo    <= '0;
          end
        end

        S_NEXT: begin
          r_tmo      <= '0;
          r_ok_cnt   <= r_ok_cnt + LEN_W'(1);
          r_beat_cnt <= w_beat_inc;
          r_addr     <= r_addr + ADDR_INC;
          if (w_beat_inc == r_len) begin
            r_state <= S_DONE;
          end else if (r_write) begin
            r_state   <= S_WR;
            r_awvalid <= 1'b1;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_wvalid  <= ~i_tx_fifo_empty;
            r_wdata   <= i_tx_fifo_data;
          end else begin
            r_state   <= S_RD_AR;
            r_arvalid <= ~i_rx_fifo_full;
          end
        end

        S_DONE: begin
          r_tmo         <= '0;
          r_done        <= 1'b1;
          r_done_status <= r_status;
          r_done_beats  <= r_ok_cnt;
          r_state       <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_burst_master.sv
// -----------------------------------------------------------------------------
// tb_axil_burst_master
//   Directed bench for axil_burst_master. A slave/FIFO model drives the DUT
//   inputs on the falling edge and logs every handshake that the next rising
//   edge will complete. Scenario tasks issue commands and compare the logs and
//   done reports against hand-computed values.
// -----------------------------------------------------------------------------
module tb_axil_burst_master;

  logic        clk;
  logic        reset_n;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic        i_cmd_write;
  logic [31:0] i_cmd_addr;
  logic [15:0] i_cmd_len;
  logic        o_busy;
  logic        o_done;
  logic [1:0]  o_done_status;
  logic [15:0] o_done_beats;
  logic [31:0] o_awaddr;
  logic        o_awvalid;
  logic        i_awready;
  logic [31:0] o_wdata;
  logic [3:0]  o_wstrb;
  logic        o_wvalid;
  logic        i_wready;
  logic [1:0]  i_bresp;
  logic        i_bvalid;
  logic        o_bready;
  logic [31:0] o_araddr;
  logic        o_arvalid;
  logic        i_arready;
  logic [31:0] i_rdata;
  logic [1:0]  i_rresp;
  logic        i_rvalid;
  logic        o_rready;
  logic [31:0] i_tx_fifo_data;
  logic        i_tx_fifo_empty;
  logic        o_tx_fifo_rd_en;
  logic [31:0] o_rx_fifo_data;
  logic        i_rx_fifo_full;
  logic        o_rx_fifo_wr_en;

  axil_burst_master #(
    .ADDR_W(32), .DATA_W(32), .LEN_W(16), .TMO_W(8), .TMO_MAX(255)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
    .i_cmd_addr(i_cmd_addr), .i_cmd_len(i_cmd_len), .o_busy(o_busy), .o_done(o_done),
    .o_done_status(o_done_status), .o_done_beats(o_done_beats),
    .o_awaddr(o_awaddr), .o_awvalid(o_awvalid), .i_awready(i_awready),
    .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wvalid(o_wvalid), .i_wready(i_wready),
    .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready),
    .o_araddr(o_araddr), .o_arvalid(o_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rvalid(i_rvalid), .o_rready(o_rready),
    .i_tx_fifo_data(i_tx_fifo_data), .i_tx_fifo_empty(i_tx_fifo_empty),
    .o_tx_fifo_rd_en(o_tx_fifo_rd_en), .o_rx_fifo_data(o_rx_fifo_data),
    .i_rx_fifo_full(i_rx_fifo_full), .o_rx_fifo_wr_en(o_rx_fifo_wr_en)
  );

  int n_vec = 0;
  int n_err = 0;

  // slave / FIFO model state
  logic [1:0]  bresp_tab [8];
  logic [31:0] rdata_tab [8];
  logic [1:0]  rresp_tab [8];
  int          b_idx, r_idx, b_owed, r_owed, proto_err;
  bit          b_fire, r_fire, cfg_awready;
  logic [31:0] tx_q [$];
  logic [31:0] aw_log [$];
  logic [31:0] w_log [$];
  logic [31:0] ar_log [$];
  logic [31:0] rx_log [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Slave model: inputs change on the falling edge; after #1 the handshakes
  // that the next rising edge will complete are visible and get logged.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        i_bvalid = 1'b0; i_rvalid = 1'b0;
        b_owed = 0; r_owed = 0; b_fire = 1'b0; r_fire = 1'b0;
      end else begin
        if (b_fire) i_bvalid = 1'b0;
        if (!i_bvalid && b_owed > 0) begin
          i_bvalid = 1'b1; i_bresp = bresp_tab[b_idx]; b_idx++; b_owed--;
        end
        if (r_fire) i_rvalid = 1'b0;
        if (!i_rvalid && r_owed > 0) begin
          i_rvalid = 1'b1; i_rdata = rdata_tab[r_idx]; i_rresp = rresp_tab[r_idx];
          r_idx++; r_owed--;
        end
      end
      i_awready       = cfg_awready;
      i_wready        = 1'b1;
      i_arready       = 1'b1;
      i_tx_fifo_empty = (tx_q.size() == 0);
      i_tx_fifo_data  = (tx_q.size() > 0) ? tx_q[0] : 32'h0;
      #1;
      if (reset_n) begin
        b_fire = i_bvalid && o_bready;
        r_fire = i_rvalid && o_rready;
        if (o_awvalid && i_awready) aw_log.push_back(o_awaddr);
        if (o_wvalid && i_wready) begin w_log.push_back(o_wdata); b_owed++; end
        if (o_arvalid && i_arready) begin ar_log.push_back(o_araddr); r_owed++; end
        if (o_rx_fifo_wr_en) rx_log.push_back(o_rx_fifo_data);
        if (o_tx_fifo_rd_en !== (o_wvalid && i_wready)) proto_err++;
        if (o_rx_fifo_wr_en !== (i_rvalid && o_rready)) proto_err++;
        if (o_tx_fifo_rd_en && tx_q.size() > 0) void'(tx_q.pop_front());
      end
    end
  end

  task automatic clear_logs();
    aw_log.delete(); w_log.delete(); ar_log.delete(); rx_log.delete();
    b_idx = 0; r_idx = 0;
    for (int i = 0; i < 8; i++) begin
      bresp_tab[i] = 2'b00; rresp_tab[i] = 2'b00; rdata_tab[i] = 32'h0;
    end
  endtask

  // Returns on the falling edge right after the accepting rising edge.
  task automatic issue_cmd(input bit wr, input logic [31:0] addr, input logic [15:0] len);
    @(negedge clk);
    for (int k = 0; k < 50 && o_cmd_ready !== 1'b1; k++) @(negedge clk);
    n_vec++;
    if (o_cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL cmd_ready before issue: got %b want 1", o_cmd_ready);
    end
    i_cmd_valid = 1'b1; i_cmd_write = wr; i_cmd_addr = addr; i_cmd_len = len;
    @(negedge clk);
    i_cmd_valid = 1'b0;
  endtask

  // cyc counts falling edges starting at 1 on the current one.
  task automatic wait_done(input int budget, output bit got, output int cyc);
    got = 1'b0; cyc = 0;
    for (int k = 1; k <= budget; k++) begin
      if (o_done === 1'b1) begin got = 1'b1; cyc = k; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec++;
    if ({o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready, o_busy, o_done} !== 7'b0) begin
      n_err++; $display("FAIL reset_outputs: got %b want 0000000",
        {o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready, o_busy, o_done});
    end
    #2 reset_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (o_cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_cmd_ready: got %b want 1", o_cmd_ready);
    end
    n_vec++;
    if ({o_done_status, o_done_beats} !== 18'h0) begin
      n_err++; $display("FAIL reset_done_regs: got %h want 0", {o_done_status, o_done_beats});
    end
    n_vec++;
    if ({o_tx_fifo_rd_en, o_rx_fifo_wr_en} !== 2'b00) begin
      n_err++; $display("FAIL reset_fifo_strobes: got %b want 00", {o_tx_fifo_rd_en, o_rx_fifo_wr_en});
    end
  endtask

  task automatic test_write_burst();
    logic [31:0] exp_a [4] = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
    logic [31:0] exp_d [4] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    logic [31:0] got_v;
    bit got; int cyc;
    clear_logs();
    for (int i = 0; i < 4; i++) tx_q.push_back(exp_d[i]);
    issue_cmd(1'b1, 32'h1000, 16'd4);
    n_vec++;
    if (o_wstrb !== 4'hF) begin n_err++; $display("FAIL wr_wstrb: got %h want f", o_wstrb); end
    wait_done(100, got, cyc);
    n_vec++;
    if (!got || cyc != 14) begin
      n_err++; $display("FAIL wr_done_latency: got done=%0b cyc=%0d want cyc=14", got, cyc);
    end
    n_vec++;
    if ({o_done_status, o_done_beats} !== {2'b00, 16'd4}) begin
      n_err++; $display("FAIL wr_status: got %b/%0d want 00/4", o_done_status, o_done_beats);
    end
    n_vec++;
    if (aw_log.size() != 4 || w_log.size() != 4) begin
      n_err++; $display("FAIL wr_beat_count: got aw=%0d w=%0d want 4/4", aw_log.size(), w_log.size());
    end
    for (int i = 0; i < 4; i++) begin
      got_v = (i < aw_log.size()) ? aw_log[i] : 32'hx;
      n_vec++;
      if (got_v !== exp_a[i]) begin n_err++; $display("FAIL wr_awaddr[%0d]: got %h want %h", i, got_v, exp_a[i]); end
      got_v = (i < w_log.size()) ? w_log[i] : 32'hx;
      n_vec++;
      if (got_v !== exp_d[i]) begin n_err++; $display("FAIL wr_wdata[%0d]: got %h want %h", i, got_v, exp_d[i]); end
    end
  endtask

  task automatic test_read_burst();
    logic [31:0] exp_a [3] = '{32'h2000, 32'h2004, 32'h2008};
    logic [31:0] exp_d [3] = '{32'h11, 32'h22, 32'h33};
    logic [31:0] got_v;
    bit got; int cyc;
    clear_logs();
    for (int i = 0; i < 3; i++) rdata_tab[i] = exp_d[i];
    issue_cmd(1'b0, 32'h2000, 16'd3);
    wait_done(100, got, cyc);
    n_vec++;
    if (!got || cyc != 11) begin
      n_err++; $display("FAIL rd_done_latency: got done=%0b cyc=%0d want cyc=11", got, cyc);
    end
    n_vec++;
    if ({o_done_status, o_done_beats} !== {2'b00, 16'd3}) begin
      n_err++; $display("FAIL rd_status: got %b/%0d want 00/3", o_done_status, o_done_beats);
    end
    n_vec++;
    if (ar_log.size() != 3 || rx_log.size() != 3) begin
      n_err++; $display("FAIL rd_beat_count: got ar=%0d rx=%0d want 3/3", ar_log.size(), rx_log.size());
    end
    for (int i = 0; i < 3; i++) begin
      got_v = (i < ar_log.size()) ? ar_log[i] : 32'hx;
      n_vec++;
      if (got_v !== exp_a[i]) begin n_err++; $display("FAIL rd_araddr[%0d]: got %h want %h", i, got_v, exp_a[i]); end
      got_v = (i < rx_log.size()) ? rx_log[i] : 32'hx;
      n_vec++;
      if (got_v !== exp_d[i]) begin n_err++; $display("FAIL rd_rxdata[%0d]: got %h want %h", i, got_v, exp_d[i]); end
    end
  endtask

  task automatic test_bresp_error();
    bit got; int cyc;
    clear_logs();
    bresp_tab[1] = 2'b10;
    tx_q.push_back(32'hB0); tx_q.push_back(32'hB1);
    issue_cmd(1'b1, 32'h3000, 16'd2);
    wait_done(100, got, cyc);
    n_vec++;
    if (!got || {o_done_status, o_done_beats} !== {2'b01, 16'd1}) begin
      n_err++; $display("FAIL bresp_status: got done=%0b %b/%0d want 01/1", got, o_done_status, o_done_beats);
    end
    n_vec++;
    if (aw_log.size() != 2) begin n_err++; $display("FAIL bresp_aw_count: got %0d want 2", aw_log.size()); end
    repeat (3) @(negedge clk);
    n_vec++;
    if ({o_done, o_done_status, o_busy} !== 4'b0010) begin
      n_err++; $display("FAIL bresp_status_held: got done=%b st=%b busy=%b want 0/01/0", o_done, o_done_status, o_busy);
    end
  endtask

  task automatic test_rx_stall();
    int ar_high;
    bit got; int cyc;
    clear_logs();
    rdata_tab[0] = 32'h4401; rdata_tab[1] = 32'h4402;
    issue_cmd(1'b0, 32'h4000, 16'd2);
    @(negedge clk);
    @(negedge clk);
    i_rx_fifo_full = 1'b1;
    ar_high = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (o_arvalid !== 1'b0) ar_high++;
    end
    i_rx_fifo_full = 1'b0;
    n_vec++;
    if (ar_high != 0) begin n_err++; $display("FAIL stall_arvalid: got %0d high cycles want 0", ar_high); end
    wait_done(100, got, cyc);
    n_vec++;
    if (!got || {o_done_status, o_done_beats} !== {2'b00, 16'd2}) begin
      n_err++; $display("FAIL stall_status: got done=%0b %b/%0d want 00/2", got, o_done_status, o_done_beats);
    end
    n_vec++;
    if (ar_log.size() != 2 || rx_log.size() != 2 || (rx_log.size() == 2 && rx_log[1] !== 32'h4402)) begin
      n_err++; $display("FAIL stall_resume: got ar=%0d rx=%0d want 2/2 last 4402", ar_log.size(), rx_log.size());
    end
  endtask

  task automatic test_rx_timeout();
    bit got; int cyc;
    clear_logs();
    rdata_tab[0] = 32'h5501;
    issue_cmd(1'b0, 32'h5000, 16'd2);
    @(negedge clk);
    @(negedge clk);
    i_rx_fifo_full = 1'b1;
    wait_done(400, got, cyc);
    i_rx_fifo_full = 1'b0;
    n_vec++;
    if (!got || cyc < 250 || cyc > 270) begin
      n_err++; $display("FAIL rx_tmo_latency: got done=%0b cyc=%0d want 250..270", got, cyc);
    end
    n_vec++;
    if ({o_done_status, o_done_beats} !== {2'b10, 16'd1}) begin
      n_err++; $display("FAIL rx_tmo_status: got %b/%0d want 10/1", o_done_status, o_done_beats);
    end
    n_vec++;
    if (ar_log.size() != 1) begin n_err++; $display("FAIL rx_tmo_ar_count: got %0d want 1", ar_log.size()); end
  endtask

  task automatic test_reset_mid_burst();
    int done_seen;
    bit got; int cyc;
    clear_logs();
    for (int i = 0; i < 4; i++) tx_q.push_back(32'hC0 + i);
    issue_cmd(1'b1, 32'h7000, 16'd4);
    repeat (3) @(negedge clk);
    n_vec++;
    if (o_awvalid !== 1'b1 || o_awaddr !== 32'h7004) begin
      n_err++; $display("FAIL midrst_beat2: got awvalid=%b awaddr=%h want 1/7004", o_awvalid, o_awaddr);
    end
    #2 reset_n = 1'b0;
    #1;
    n_vec++;
    if ({o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready, o_busy} !== 6'b0) begin
      n_err++; $display("FAIL midrst_valids: got %b want 000000",
        {o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready, o_busy});
    end
    done_seen = 0;
    @(negedge clk);
    if (o_done !== 1'b0) done_seen++;
    #2 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (o_done !== 1'b0) done_seen++;
    end
    n_vec++;
    if (done_seen != 0) begin n_err++; $display("FAIL midrst_no_done: got %0d pulses want 0", done_seen); end
    n_vec++;
    if ({o_cmd_ready, o_done_status} !== 3'b100) begin
      n_err++; $display("FAIL midrst_idle: got ready=%b st=%b want 1/00", o_cmd_ready, o_done_status);
    end
    tx_q.delete();
    clear_logs();
    tx_q.push_back(32'hD0); tx_q.push_back(32'hD1);
    issue_cmd(1'b1, 32'h8000, 16'd2);
    wait_done(100, got, cyc);
    n_vec++;
    if (!got || {o_done_status, o_done_beats} !== {2'b00, 16'd2}) begin
      n_err++; $display("FAIL midrst_next_status: got done=%0b %b/%0d want 00/2", got, o_done_status, o_done_beats);
    end
    n_vec++;
    if (aw_log.size() != 2 || aw_log[0] !== 32'h8000 || aw_log[1] !== 32'h8004) begin
      n_err++; $display("FAIL midrst_next_addr: got n=%0d first=%h want 2 from 8000",
        aw_log.size(), (aw_log.size() > 0) ? aw_log[0] : 32'hx);
    end
    n_vec++;
    if (w_log.size() != 2 || w_log[0] !== 32'hD0 || w_log[1] !== 32'hD1) begin
      n_err++; $display("FAIL midrst_next_data: got n=%0d want D0,D1", w_log.size());
    end
  endtask

  task automatic test_aw_timeout();
    bit got; int cyc;
    clear_logs();
    cfg_awready = 1'b0;
    tx_q.push_back(32'hE0);
    issue_cmd(1'b1, 32'h9000, 16'd1);
    wait_done(400, got, cyc);
    cfg_awready = 1'b1;
    n_vec++;
    if (!got || cyc < 250 || cyc > 270) begin
      n_err++; $display("FAIL aw_tmo_latency: got done=%0b cyc=%0d want 250..270", got, cyc);
    end
    n_vec++;
    if ({o_done_status, o_done_beats} !== {2'b10, 16'd0}) begin
      n_err++; $display("FAIL aw_tmo_status: got %b/%0d want 10/0", o_done_status, o_done_beats);
    end
    n_vec++;
    if (aw_log.size() != 0 || o_awvalid !== 1'b0) begin
      n_err++; $display("FAIL aw_tmo_no_aw: got n=%0d awvalid=%b want 0/0", aw_log.size(), o_awvalid);
    end
  endtask

  task automatic test_len_zero();
    bit got; int cyc;
    clear_logs();
    issue_cmd(1'b1, 32'h6000, 16'd0);
    wait_done(20, got, cyc);
    n_vec++;
    if (!got || cyc != 2) begin
      n_err++; $display("FAIL len0_latency: got done=%0b cyc=%0d want 2", got, cyc);
    end
    n_vec++;
    if ({o_done_status, o_done_beats} !== {2'b00, 16'd0}) begin
      n_err++; $display("FAIL len0_status: got %b/%0d want 00/0", o_done_status, o_done_beats);
    end
    n_vec++;
    if (aw_log.size() + w_log.size() + ar_log.size() != 0) begin
      n_err++; $display("FAIL len0_bus_idle: got %0d handshakes want 0", aw_log.size() + w_log.size() + ar_log.size());
    end
  endtask

  task automatic test_fifo_strobes();
    n_vec++;
    if (proto_err != 0) begin
      n_err++; $display("FAIL fifo_strobe_alignment: got %0d violations want 0", proto_err);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    i_cmd_valid = 1'b0; i_cmd_write = 1'b0; i_cmd_addr = 32'h0; i_cmd_len = 16'h0;
    i_awready = 1'b0; i_wready = 1'b0; i_arready = 1'b0;
    i_bresp = 2'b00; i_bvalid = 1'b0; i_rdata = 32'h0; i_rresp = 2'b00; i_rvalid = 1'b0;
    i_tx_fifo_data = 32'h0; i_tx_fifo_empty = 1'b1; i_rx_fifo_full = 1'b0;
    cfg_awready = 1'b1; proto_err = 0;
    b_idx = 0; r_idx = 0; b_owed = 0; r_owed = 0;
    clear_logs();
    test_reset();
    test_write_burst();
    test_read_burst();
    test_bresp_error();
    test_rx_stall();
    test_rx_timeout();
    test_reset_mid_burst();
    test_aw_timeout();
    test_len_zero();
    test_fifo_strobes();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
